// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding, strobe width
// and master index constants.
package bus_pkg;

    localparam int DS_W = 2;
    localparam int M0   = 0;
    localparam int M1   = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2,
        ST_HOLD0   = 2'd3
    } state_t;

endpackage

// File: rtl/arb_pick2.sv
// Two-way request picker: round-robin against the last served master, or
// fixed priority with m0 winning ties.
module arb_pick2 #(
    parameter int RR = 1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            // last=1 means m1 was served most recently
            2'b11:   pick = ((RR != 0) && !last) ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the slave bus: grants one master at a time,
// forwards its cycle, routes ack back and aborts cycles that are never acked.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | bus free, sample both requests and pick an owner
//   BUSY    | cycle forwarded to slave, waiting for s_ack or timeout
//   RECOVER | one dead cycle after a cycle ends, masters drop req
//   HOLD0   | m0 holds the bus between locked cycles, m1 blocked
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_write,
    input  logic [DS_W-1:0]   m0_ds,
    input  logic              m0_rw,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_read,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_write,
    input  logic [DS_W-1:0]   m1_ds,
    input  logic              m1_rw,
    output logic [DATA_W-1:0] m1_read,
    output logic              m1_ack,
    output logic              m1_err,

    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_write,
    output logic [DS_W-1:0]   s_ds,
    output logic              s_rw,
    input  logic [DATA_W-1:0] s_read,
    input  logic              s_ack,

    output logic [1:0]        grant,
    output logic              timeout_seen
);

    // A zero TIMEOUT still needs a legal one-bit timer vector.
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    state_t           state, state_nx;
    logic [1:0]       grant_q, grant_nx;
    logic             last_q, last_nx;
    logic [TMR_W-1:0] timer_q, timer_nx;
    logic [1:0]       err_q, err_nx;
    logic             tseen_q, tseen_nx;
    logic [1:0]       pick;
    logic             busy;
    logic             expired;

    arb_pick2 #(.RR(RR)) u_pick (
        .req  ({m1_req, m0_req}),
        .last (last_q),
        .pick (pick)
    );

    assign busy    = (state == ST_BUSY);
    assign expired = (TIMEOUT != 0) && (timer_q == TMR_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            timer_q <= '0;
            err_q   <= 2'b00;
            tseen_q <= 1'b0;
        end else begin
            state   <= state_nx;
            grant_q <= grant_nx;
            last_q  <= last_nx;
            timer_q <= timer_nx;
            err_q   <= err_nx;
            tseen_q <= tseen_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        last_nx  = last_q;
        timer_nx = '0;
        err_nx   = 2'b00;
        tseen_nx = tseen_q;
        case (state)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    grant_nx = pick;
                    state_nx = ST_BUSY;
                end
            end
            ST_HOLD0: begin
                if (m0_req) begin
                    grant_nx = 2'b01;
                    state_nx = ST_BUSY;
                end else if (!m0_lock) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // An ack landing on the expiry cycle still completes normally.
                if (s_ack) begin
                    last_nx  = grant_q[M1];
                    grant_nx = 2'b00;
                    state_nx = (grant_q[M0] && m0_lock) ? ST_HOLD0 : ST_RECOVER;
                end else if (expired) begin
                    err_nx   = grant_q;
                    tseen_nx = 1'b1;
                    grant_nx = 2'b00;
                    state_nx = ST_RECOVER;
                end else if (TIMEOUT != 0) begin
                    timer_nx = timer_q + TMR_W'(1);
                end
            end
            ST_RECOVER: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = 2'b00;
            end
        endcase
    end

    // grant_q is zero outside BUSY, so the idle mux value is m0's.
    assign s_addr  = grant_q[M1] ? m1_addr  : m0_addr;
    assign s_write = grant_q[M1] ? m1_write : m0_write;
    assign s_rw    = grant_q[M1] ? m1_rw    : m0_rw;
    assign s_ds    = busy ? (grant_q[M1] ? m1_ds : m0_ds) : '0;

    assign m0_ack  = busy & s_ack & grant_q[M0];
    assign m1_ack  = busy & s_ack & grant_q[M1];
    assign m0_err  = err_q[M0];
    assign m1_err  = err_q[M1];
    assign m0_read = s_read;
    assign m1_read = s_read;

    assign grant        = grant_q;
    assign timeout_seen = tseen_q;

endmodule
